// File: rtl/slow_clk_monitor_if.sv
// Bundles the monitored slow clock and the measurement results of slow_clk_monitor.
// slave: the monitor itself; master: whoever drives slow_in and consumes the results.
interface slow_clk_monitor_if #(
    parameter int W = 32
);
    logic         slow_in;
    logic         rise_pulse;
    logic         fall_pulse;
    logic [W-1:0] period;
    logic         period_valid;
    logic         stall;

    modport slave (
        input  slow_in,
        output rise_pulse,
        output fall_pulse,
        output period,
        output period_valid,
        output stall
    );

    modport master (
        output slow_in,
        input  rise_pulse,
        input  fall_pulse,
        input  period,
        input  period_valid,
        input  stall
    );
endinterface

// File: rtl/slow_clk_monitor.sv
// Synchronises a slow clock into clk, emits rise/fall enables (SYNC_STAGES edges after sampling),
// measures rising-edge period and flags a stalled slow clock; no backpressure, outputs always live.
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 32,
    parameter int TIMEOUT     = 600000
) (
    input  logic                clk,
    input  logic                rst,
    slow_clk_monitor_if.slave   mon
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("slow_clk_monitor: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("slow_clk_monitor: TIMEOUT must be >= 2");
    end

    localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   rise_q;
    logic                   fall_q;
    logic [W-1:0]           cnt_q;
    logic [W-1:0]           period_q;
    logic                   period_we;
    state_t                 state_q;
    state_t                 state_d;

    // slow_in is asynchronous: only the last synchroniser stage is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.slow_in};
            prev_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise;
            fall_q <= fall;
        end
    end

    // Cycles since the last rising edge; saturation keeps it from wrapping while stalled or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise on the same cycle the counter saturates takes priority over the stall.
    always_comb begin
        state_d   = state_q;
        period_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = ARMED;
            end
            ARMED, RUN: begin
                if (rise) begin
                    state_d   = RUN;
                    period_we = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (rise) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
        end else if (period_we) begin
            period_q <= cnt_q + W'(1);
        end
    end

    assign mon.rise_pulse   = rise_q;
    assign mon.fall_pulse   = fall_q;
    assign mon.period       = period_q;
    assign mon.period_valid = (state_q == RUN);
    assign mon.stall        = (state_q == STALL);

endmodule
